// File: rtl/mux_n_para_um_seq.sv
// Registered N:1 operand multiplexer with a valid/ready output port.
// Direct mode presents one selected channel; scan mode walks channels 0..N-1 in order.
module mux_n_para_um_seq #(
    parameter int WIDTH = 16,
    parameter int N     = 6,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N*WIDTH-1:0]   entradas,
    input  logic [SELW-1:0]      op,
    input  logic                 modo,
    input  logic                 iniciar,
    input  logic                 saida_ready,
    output logic [WIDTH-1:0]     saida,
    output logic                 saida_valid,
    output logic [SELW-1:0]      canal,
    output logic                 ocupado,
    output logic                 fim
);

    typedef enum logic [1:0] {
        OCIOSO,
        DIRETO,
        VARREDURA
    } state_t;

    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    state_t             state;
    state_t             state_next;
    logic [SELW-1:0]    canal_next;
    logic [WIDTH-1:0]   saida_next;
    logic               valid_next;
    logic               fim_next;
    logic [SELW-1:0]    op_clamp;
    logic [SELW-1:0]    load_idx;
    logic               load;
    logic               transfer;

    // Loop-based mux keeps the channel lookup safe when N is not a power of two.
    function automatic logic [WIDTH-1:0] pick(input logic [SELW-1:0]    idx,
                                              input logic [N*WIDTH-1:0] bus);
        logic [WIDTH-1:0] word;
        word = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SELW'(k)) begin
                word = bus[k*WIDTH +: WIDTH];
            end
        end
        return word;
    endfunction

    assign op_clamp = (op > LAST) ? LAST : op;
    assign transfer = saida_valid & saida_ready;
    assign ocupado  = (state != OCIOSO);

    always_comb begin
        state_next = state;
        canal_next = canal;
        valid_next = saida_valid;
        fim_next   = 1'b0;
        load       = 1'b0;
        load_idx   = canal;

        case (state)
            OCIOSO: begin
                if (iniciar) begin
                    load       = 1'b1;
                    valid_next = 1'b1;
                    if (modo) begin
                        load_idx   = '0;
                        state_next = VARREDURA;
                    end else begin
                        load_idx   = op_clamp;
                        state_next = DIRETO;
                    end
                    canal_next = load_idx;
                end
            end

            DIRETO: begin
                if (transfer) begin
                    valid_next = 1'b0;
                    fim_next   = 1'b1;
                    state_next = OCIOSO;
                end
            end

            VARREDURA: begin
                if (transfer) begin
                    if (canal == LAST) begin
                        valid_next = 1'b0;
                        fim_next   = 1'b1;
                        state_next = OCIOSO;
                    end else begin
                        load       = 1'b1;
                        load_idx   = canal + SELW'(1);
                        canal_next = load_idx;
                    end
                end
            end

            default: begin
                state_next = OCIOSO;
                valid_next = 1'b0;
            end
        endcase

        // saida only moves on a load edge, so it holds through stalls and after fim.
        saida_next = load ? pick(load_idx, entradas) : saida;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= OCIOSO;
            canal       <= '0;
            saida       <= '0;
            saida_valid <= 1'b0;
            fim         <= 1'b0;
        end else begin
            state       <= state_next;
            canal       <= canal_next;
            saida       <= saida_next;
            saida_valid <= valid_next;
            fim         <= fim_next;
        end
    end

endmodule

// File: tb/tb_mux_n_para_um_seq.sv
// Randomized self-checking bench: each operation's expected word list is built from the
// channel values at start time, and loaded channels are scrambled to prove capture.
module tb_mux_n_para_um_seq;

    localparam int WIDTH = 16;
    localparam int N     = 6;
    localparam int SELW  = $clog2(N);

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [N*WIDTH-1:0]   entradas;
    logic [SELW-1:0]      op;
    logic                 modo;
    logic                 iniciar;
    logic                 saida_ready;
    logic [WIDTH-1:0]     saida;
    logic                 saida_valid;
    logic [SELW-1:0]      canal;
    logic                 ocupado;
    logic                 fim;

    logic [WIDTH-1:0]     ch [N];
    int                   n_checks   = 0;
    int                   n_failures = 0;

    mux_n_para_um_seq #(.WIDTH(WIDTH), .N(N)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .entradas    (entradas),
        .op          (op),
        .modo        (modo),
        .iniciar     (iniciar),
        .saida_ready (saida_ready),
        .saida       (saida),
        .saida_valid (saida_valid),
        .canal       (canal),
        .ocupado     (ocupado),
        .fim         (fim)
    );

    always #5 clock = ~clock;

    always_comb begin
        entradas = '0;
        for (int k = 0; k < N; k++) entradas[k*WIDTH +: WIDTH] = ch[k];
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            iniciar     = 1'b0;
            saida_ready = 1'($urandom_range(0, 1));
            step();
            check_output("idle_valid", saida_valid, 0);
            check_output("idle_fim", fim, 0);
            check_output("idle_ocupado", ocupado, 0);
        end
    endtask

    // Starts an operation from the current (idle or fim) cycle and follows it to its fim pulse.
    // stall_pct < 0 gives the alternating ready pattern 1,0,1,0...
    task automatic run_op(input logic m, input logic [SELW-1:0] o, input int stall_pct, input bit noise);
        logic [WIDTH-1:0] ev [$];
        int               ec [$];
        int               k;
        int               cyc;
        int               stalls;
        int               c;
        logic             rdy;

        if (m == 1'b0) begin
            c = (int'(o) > N - 1) ? N - 1 : int'(o);
            ev.push_back(ch[c]);
            ec.push_back(c);
        end else begin
            for (int j = 0; j < N; j++) begin
                ev.push_back(ch[j]);
                ec.push_back(j);
            end
        end

        modo        = m;
        op          = o;
        iniciar     = 1'b1;
        saida_ready = 1'($urandom_range(0, 1));
        step();
        iniciar = 1'b0;
        modo    = 1'($urandom);
        op      = SELW'($urandom);

        k      = 0;
        cyc    = 0;
        stalls = 0;
        while (k < ev.size() && cyc < 200) begin
            check_output("valid", saida_valid, 1);
            check_output("saida", saida, ev[k]);
            check_output("canal", canal, ec[k]);
            check_output("ocupado", ocupado, 1);
            check_output("fim_early", fim, 0);
            ch[ec[k]] = WIDTH'($urandom);
            if (stall_pct < 0)       rdy = ((cyc % 2) == 0);
            else if (stalls >= 8)    rdy = 1'b1;
            else                     rdy = ($urandom_range(0, 99) >= stall_pct);
            saida_ready = rdy;
            if (noise) begin
                iniciar = 1'($urandom);
                modo    = 1'($urandom);
                op      = SELW'($urandom);
            end
            if (rdy) begin
                k++;
                stalls = 0;
            end else begin
                stalls++;
            end
            step();
            cyc++;
        end
        if (k < ev.size()) check_output("op_timeout", k, ev.size());
        iniciar = 1'b0;
        check_output("fim", fim, 1);
        check_output("end_valid", saida_valid, 0);
        check_output("end_ocupado", ocupado, 0);
        check_output("saida_hold", saida, ev[ev.size()-1]);
        saida_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        iniciar     = 1'b0;
        modo        = 1'b0;
        op          = '0;
        saida_ready = 1'b0;
        for (int k = 0; k < N; k++) ch[k] = WIDTH'(16'h0010 + k);

        repeat (2) @(posedge clock);
        #1;
        check_output("rst_saida", saida, 0);
        check_output("rst_valid", saida_valid, 0);
        check_output("rst_canal", canal, 0);
        check_output("rst_ocupado", ocupado, 0);
        check_output("rst_fim", fim, 0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(3);

        // Direct mode, in-range and out-of-range select
        ch[2] = 16'h00A5;
        run_op(1'b0, SELW'(2), 0, 1'b0);
        idle(2);
        ch[5] = 16'hBEEF;
        run_op(1'b0, SELW'(7), 0, 1'b0);
        idle(1);
        run_op(1'b0, SELW'(6), 30, 1'b0);
        idle(1);

        // Scan with alternating ready, then full rate
        for (int k = 0; k < N; k++) ch[k] = WIDTH'(16'h0010 + k);
        run_op(1'b1, '0, -1, 1'b0);
        idle(2);
        for (int k = 0; k < N; k++) ch[k] = WIDTH'(16'h0010 + k);
        run_op(1'b1, '0, 0, 1'b0);
        idle(1);

        // Busy iniciar ignored, then back-to-back start in the fim cycle
        run_op(1'b1, '0, 40, 1'b1);
        run_op(1'b0, SELW'(1), 0, 1'b0);
        idle(1);

        // Asynchronous reset mid-scan at canal = 3
        for (int k = 0; k < N; k++) ch[k] = WIDTH'($urandom);
        modo        = 1'b1;
        iniciar     = 1'b1;
        saida_ready = 1'b1;
        step();
        iniciar = 1'b0;
        repeat (3) step();
        check_output("pre_rst_canal", canal, 3);
        check_output("pre_rst_saida", saida, ch[3]);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("arst_saida", saida, 0);
        check_output("arst_valid", saida_valid, 0);
        check_output("arst_canal", canal, 0);
        check_output("arst_ocupado", ocupado, 0);
        check_output("arst_fim", fim, 0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(4);

        // Randomized operations, sometimes back-to-back
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < N; k++) ch[k] = WIDTH'($urandom);
            run_op(1'($urandom), SELW'($urandom), int'($urandom_range(0, 70)), 1'($urandom));
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
